// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry, bus widths, pixel type and fill FSM states.
package fb_pkg;
    localparam int FB_H_RES  = 640;
    localparam int FB_V_RES  = 480;
    localparam int FB_ADDR_W = 19;
    localparam int FB_WORD_W = 32;
    typedef logic [7:0] pixel_t;
    typedef enum logic [1:0] {IDLE, SETUP, WRITE, FINISH} state_t;
endpackage

// File: rtl/fb_fill_engine_if.sv
// fb_fill_engine_if: fill command handshake between a requester and the fill engine.
interface fb_fill_engine_if;
    import fb_pkg::*;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_x;
    logic [8:0] cmd_y;
    logic [9:0] cmd_w;
    logic [8:0] cmd_h;
    pixel_t     cmd_color;
    modport master (output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, input cmd_ready);
    modport slave  (input cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, output cmd_ready);
endinterface

// File: rtl/fb_edge_mask.sv
// fb_edge_mask: byte-lane write masks for the first, last and single word of a row span.
module fb_edge_mask (
    input  logic [1:0] i_start,
    input  logic [1:0] i_end,
    output logic [3:0] o_first,
    output logic [3:0] o_last,
    output logic [3:0] o_single
);
    assign o_first  = 4'b1111 << i_start;
    assign o_last   = 4'b1111 >> (2'd3 - i_end);
    assign o_single = o_first & o_last;
endmodule

// File: rtl/fb_fill_engine.sv
// fb_fill_engine: fills a rectangle of a linear RGB332 framebuffer one 32-bit word per cycle.
// Define FB_FILL_CLIP_EN to clip off-screen rectangles; otherwise they are rejected with err.
module fb_fill_engine
    import fb_pkg::*;
#(
    parameter int H_RES = FB_H_RES,
    parameter int V_RES = FB_V_RES
) (
    input  logic                 clk,
    input  logic                 resetn,
    fb_fill_engine_if.slave      cmd,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [FB_ADDR_W-1:0] bram_addra,
    output logic [FB_WORD_W-1:0] bram_dina,
    output logic                 bram_ena,
    output logic [3:0]           bram_wea,
    output logic                 bram_rsta,
    output logic                 bram_clka
);
    localparam logic [10:0] L_HRES  = 11'(H_RES);
    localparam logic [9:0]  L_VRES  = 10'(V_RES);
    localparam logic [18:0] L_HSTEP = 19'(H_RES);

    state_t        r_state, w_next;
    logic [9:0]    r_x, r_w;
    logic [8:0]    r_y, r_h, r_row, r_hlast;
    pixel_t        r_color;
    logic [18:0]   r_addr, r_row_addr;
    logic [7:0]    r_col, r_wlast;
    logic [3:0]    r_first, r_last, r_single;
    logic          r_err;

    logic [10:0]   w_xw, w_end;
    logic [9:0]    w_yh, w_w;
    logic [8:0]    w_h;
    logic [7:0]    w_wlast;
    logic [18:0]   w_row0;
    logic [3:0]    w_first, w_last, w_single;
    logic          w_bad, w_zero, w_hs, w_col_end, w_row_end;

    // sums kept one bit wider so an oversize rectangle cannot wrap back on-screen
    assign w_xw = {1'b0, r_x} + {1'b0, r_w};
    assign w_yh = {1'b0, r_y} + {1'b0, r_h};
`ifdef FB_FILL_CLIP_EN
    assign w_w   = ({1'b0, r_x} >= L_HRES) ? '0 : (w_xw > L_HRES) ? 10'(H_RES) - r_x : r_w;
    assign w_h   = ({1'b0, r_y} >= L_VRES) ? '0 : (w_yh > L_VRES) ? 9'(V_RES) - r_y : r_h;
    assign w_bad = 1'b0;
`else
    assign w_w   = r_w;
    assign w_h   = r_h;
    assign w_bad = (w_xw > L_HRES) || (w_yh > L_VRES);
`endif
    assign w_zero    = w_bad || (w_w == '0) || (w_h == '0);
    assign w_end     = {1'b0, r_x} + {1'b0, w_w} - 11'd1;
    assign w_wlast   = 8'(w_end[10:2] - {1'b0, r_x[9:2]});
    assign w_row0    = 19'(r_y) * L_HSTEP + {9'd0, r_x[9:2], 2'b00};
    assign w_hs      = cmd.cmd_valid && (r_state == IDLE);
    assign w_col_end = r_col == r_wlast;
    assign w_row_end = r_row == r_hlast;
    assign bram_rsta = ~resetn;
    assign bram_clka = clk;

    fb_edge_mask u_mask (
        .i_start (r_x[1:0]),
        .i_end   (w_end[1:0]),
        .o_first (w_first),
        .o_last  (w_last),
        .o_single(w_single)
    );

    always_ff @(posedge clk)
        r_state <= !resetn ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_hs ? SETUP : IDLE;
            SETUP:   w_next = w_zero ? FINISH : WRITE;
            WRITE:   w_next = (w_col_end && w_row_end) ? FINISH : WRITE;
            default: w_next = IDLE;
        endcase
        cmd.cmd_ready = r_state == IDLE;
        busy          = r_state != IDLE;
        done          = (r_state == FINISH) && !r_err;
        err           = (r_state == FINISH) && r_err;
        bram_ena      = r_state == WRITE;
        bram_addra    = bram_ena ? r_addr : '0;
        bram_dina     = bram_ena ? {4{r_color}} : '0;
        bram_wea      = !bram_ena ? 4'h0 : (r_col == '0) ? (w_col_end ? r_single : r_first) :
                        w_col_end ? r_last : 4'hF;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            {r_x, r_w, r_y, r_h, r_color} <= '0;
            {r_addr, r_row_addr, r_col, r_wlast, r_row, r_hlast} <= '0;
            {r_first, r_last, r_single, r_err} <= '0;
        end else begin
            if (w_hs) begin
                r_x     <= cmd.cmd_x;
                r_y     <= cmd.cmd_y;
                r_w     <= cmd.cmd_w;
                r_h     <= cmd.cmd_h;
                r_color <= cmd.cmd_color;
            end
            if (r_state == SETUP) begin
                r_addr     <= w_row0;
                r_row_addr <= w_row0;
                r_col      <= '0;
                r_row      <= '0;
                r_wlast    <= w_wlast;
                r_hlast    <= w_h - 9'd1;
                r_first    <= w_first;
                r_last     <= w_last;
                r_single   <= w_single;
                r_err      <= w_bad;
            end
            if (r_state == WRITE) begin
                r_col      <= w_col_end ? '0 : r_col + 8'd1;
                r_row      <= w_col_end ? r_row + 9'd1 : r_row;
                r_row_addr <= w_col_end ? r_row_addr + L_HSTEP : r_row_addr;
                r_addr     <= w_col_end ? r_row_addr + L_HSTEP : r_addr + 19'd4;
            end
        end
    end
endmodule
